// File: rtl/ind_mux_ctrl.sv
// ind_mux_ctrl: multiplexes PRD (transmitter) and PRM (receiver) command
// flags onto one shared LED bank. Each command is stretched by a per-channel
// hold counter. The bank alternates between directions every DWELL_TICKS
// ticks while both are active. ind_prm_prd tells which direction is shown.
// Optional build macro: IND_BLINK_EN makes a channel that is active in both
// directions blink at the tick rate.

// Per-channel hold counter: the command is stretched for HOLD_TICKS ticks
// after it falls.
module ind_hold_cnt #(
  parameter int HOLD_TICKS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic cmd_i,
  output logic act_o
);
  localparam logic [3:0] HOLD = 4'(HOLD_TICKS);

  logic [3:0] hold_q, hold_d;

  // Reload while commanded, which includes a tick that coincides with a
  // rising command. Count down on ticks otherwise, stopping at 0.
  always_comb begin
    hold_d = hold_q;
    if (cmd_i)                          hold_d = HOLD;
    else if (tick_i && hold_q != 4'd0)  hold_d = hold_q - 4'd1;
  end

  // Hold counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= 4'd0;
    else        hold_q <= hold_d;
  end

  assign act_o = cmd_i | (hold_q != 4'd0);
endmodule

module ind_mux_ctrl #(
  parameter int WIDTH       = 8,
  parameter int HOLD_TICKS  = 8,
  parameter int DWELL_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_in,
  input  logic [WIDTH-1:0] prd_cmd,
  input  logic [WIDTH-1:0] prm_cmd,
  output logic [WIDTH-1:0] led,
  output logic             ind_prm_prd
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRD  = 2'd1;
  localparam logic [1:0] S_PRM  = 2'd2;
  localparam logic [3:0] DWELL_LAST = 4'(DWELL_TICKS - 1);

  logic             tick_in_q, tick;
  logic [WIDTH-1:0] prd_act, prm_act, blink_mask;
  logic             prd_any, prm_any;
  logic [1:0]       state_q, state_d;
  logic [3:0]       dwell_q, dwell_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             ind_q, ind_d;

  // Tick edge detect: one clk pulse per rising edge of the divider tap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_in_q <= 1'b0;
    else        tick_in_q <= tick_in;
  end
  assign tick = tick_in & ~tick_in_q;

  ind_hold_cnt #(.HOLD_TICKS(HOLD_TICKS)) u_prd [WIDTH-1:0] (
    .clk(clk), .rst_n(rst_n), .tick_i(tick), .cmd_i(prd_cmd), .act_o(prd_act));
  ind_hold_cnt #(.HOLD_TICKS(HOLD_TICKS)) u_prm [WIDTH-1:0] (
    .clk(clk), .rst_n(rst_n), .tick_i(tick), .cmd_i(prm_cmd), .act_o(prm_act));

  assign prd_any = |prd_act;
  assign prm_any = |prm_act;

`ifdef IND_BLINK_EN
  logic phase_q;

  // Blink phase flips on every tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    phase_q <= 1'b0;
    else if (tick) phase_q <= ~phase_q;
  end
  // Channels active in both directions are gated by the phase
  assign blink_mask = ~(prd_act & prm_act) | {WIDTH{phase_q}};
`else
  assign blink_mask = '1;
`endif

  // Direction arbitration. PRD wins ties from IDLE. A direction leaves
  // early as soon as it has nothing left to show. At the end of a dwell it
  // hands over only if the other side has something to show.
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    case (state_q)
      S_IDLE: begin
        dwell_d = 4'd0;
        if (prd_any)      state_d = S_PRD;
        else if (prm_any) state_d = S_PRM;
      end
      S_PRD: begin
        if (!prd_any) begin
          state_d = prm_any ? S_PRM : S_IDLE;
          dwell_d = 4'd0;
        end else if (tick) begin
          if (dwell_q == DWELL_LAST) begin
            dwell_d = 4'd0;
            if (prm_any) state_d = S_PRM;
          end else begin
            dwell_d = dwell_q + 4'd1;
          end
        end
      end
      S_PRM: begin
        if (!prm_any) begin
          state_d = prd_any ? S_PRD : S_IDLE;
          dwell_d = 4'd0;
        end else if (tick) begin
          if (dwell_q == DWELL_LAST) begin
            dwell_d = 4'd0;
            if (prd_any) state_d = S_PRD;
          end else begin
            dwell_d = dwell_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        dwell_d = 4'd0;
      end
    endcase
  end

  // Output selection from the current state. ind holds its value in IDLE.
  always_comb begin
    led_d = '0;
    ind_d = ind_q;
    case (state_q)
      S_PRD:   begin led_d = prd_act & blink_mask; ind_d = 1'b1; end
      S_PRM:   begin led_d = prm_act & blink_mask; ind_d = 1'b0; end
      default: led_d = '0;
    endcase
  end

  // FSM and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dwell_q <= 4'd0;
      led_q   <= '0;
      ind_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      led_q   <= led_d;
      ind_q   <= ind_d;
    end
  end

  assign led         = led_q;
  assign ind_prm_prd = ind_q;
endmodule

// File: tb/tb_ind_mux_ctrl.sv
// Bench for ind_mux_ctrl: directed scenario tasks plus a randomized run
// checked against a tick-counting reference model.
module tb_ind_mux_ctrl;
  localparam int W     = 8;
  localparam int HOLD  = 8;
  localparam int DWELL = 4;

  logic         clk, rst_n, tick_in;
  logic [W-1:0] prd_cmd, prm_cmd, led;
  logic         ind_prm_prd;
  int           n_cmp, n_err, tick_cnt;

  ind_mux_ctrl #(.WIDTH(W), .HOLD_TICKS(HOLD), .DWELL_TICKS(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .prd_cmd(prd_cmd),
    .prm_cmd(prm_cmd), .led(led), .ind_prm_prd(ind_prm_prd));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider tap: square wave with an 8-clk period, changing just after posedge
  initial begin
    tick_in  = 1'b0;
    tick_cnt = 0;
    forever begin
      repeat (4) @(posedge clk);
      #2;
      tick_in = ~tick_in;
      if (tick_in) tick_cnt++;
    end
  end

  // Reference model: per channel, the number of ticks seen since the command
  // went low, saturating at HOLD; a channel counts as active while commanded
  // or while fewer than HOLD ticks have passed.
  int           sp [W];
  int           sq [W];
  logic         m_tq, m_ind, m_ph;
  int           m_dir;   // 0 none, 1 PRD, 2 PRM
  int           m_dw;    // ticks already shown in the current dwell
  logic [W-1:0] m_led, pa, qa, mask;
  logic         tk;

  assign tk = tick_in & ~m_tq;
  for (genvar g = 0; g < W; g++) begin : g_act
    assign pa[g] = prd_cmd[g] || (sp[g] < HOLD);
    assign qa[g] = prm_cmd[g] || (sq[g] < HOLD);
  end
`ifdef IND_BLINK_EN
  assign mask = ~(pa & qa) | {W{m_ph}};
`else
  assign mask = '1;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < W; i++) begin sp[i] <= HOLD; sq[i] <= HOLD; end
      m_tq <= 1'b0; m_dir <= 0; m_dw <= 0; m_led <= '0; m_ind <= 1'b0; m_ph <= 1'b0;
    end else begin
      m_tq <= tick_in;
      for (int i = 0; i < W; i++) begin
        sp[i] <= prd_cmd[i] ? 0 : (tk && sp[i] < HOLD) ? sp[i] + 1 : sp[i];
        sq[i] <= prm_cmd[i] ? 0 : (tk && sq[i] < HOLD) ? sq[i] + 1 : sq[i];
      end
      if (tk) m_ph <= ~m_ph;
      m_led <= (m_dir == 1) ? (pa & mask) : (m_dir == 2) ? (qa & mask) : '0;
      if (m_dir == 1) m_ind <= 1'b1;
      else if (m_dir == 2) m_ind <= 1'b0;
      case (m_dir)
        0: begin
          if (|pa) begin m_dir <= 1; m_dw <= 0; end
          else if (|qa) begin m_dir <= 2; m_dw <= 0; end
        end
        1: begin
          if (!(|pa)) begin m_dir <= (|qa) ? 2 : 0; m_dw <= 0; end
          else if (tk) begin
            if (m_dw + 1 == DWELL) begin m_dw <= 0; if (|qa) m_dir <= 2; end
            else m_dw <= m_dw + 1;
          end
        end
        default: begin
          if (!(|qa)) begin m_dir <= (|pa) ? 1 : 0; m_dw <= 0; end
          else if (tk) begin
            if (m_dw + 1 == DWELL) begin m_dw <= 0; if (|pa) m_dir <= 1; end
            else m_dw <= m_dw + 1;
          end
        end
      endcase
    end
  end

  // Wait for the next tick_in rise; returns on the following negedge
  task automatic wait_tick();
    int c, k;
    c = tick_cnt;
    k = 0;
    while (tick_cnt == c && k < 100) begin @(negedge clk); k++; end
    if (tick_cnt == c) begin
      n_cmp++; n_err++;
      $display("FAIL wait_tick: no tick_in rise within %0d clk", k);
    end
  endtask

  // Drop all commands and let every hold counter run out
  task automatic settle();
    @(negedge clk);
    prd_cmd = '0; prm_cmd = '0;
    repeat (HOLD + 3) wait_tick();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; prd_cmd = 8'hFF; prm_cmd = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (led !== 8'h00) begin n_err++; $display("FAIL reset_led: got %h want 00", led); end
    n_cmp++; if (ind_prm_prd !== 1'b0) begin n_err++; $display("FAIL reset_ind: got %b want 0", ind_prm_prd); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (led !== 8'hFF) begin n_err++; $display("FAIL release_led: got %h want ff", led); end
    n_cmp++; if (ind_prm_prd !== 1'b1) begin n_err++; $display("FAIL release_ind: got %b want 1", ind_prm_prd); end
  endtask

  task automatic test_stretch();
    settle();
    wait_tick();
    @(negedge clk); prd_cmd = 8'h08;
    @(negedge clk); prd_cmd = 8'h00;
    for (int t = 1; t <= HOLD; t++) begin
      wait_tick();
      n_cmp++;
      if (led !== 8'h08) begin n_err++; $display("FAIL stretch_hi tick %0d: got %h want 08", t, led); end
    end
    repeat (2) @(negedge clk);
    n_cmp++; if (led !== 8'h00) begin n_err++; $display("FAIL stretch_lo: got %h want 00", led); end
    n_cmp++; if (ind_prm_prd !== 1'b1) begin n_err++; $display("FAIL stretch_ind_hold: got %b want 1", ind_prm_prd); end
  endtask

  task automatic test_alternate();
    int last, nchg;
    logic [W-1:0] prev;
    settle();
    @(negedge clk); prd_cmd = 8'h01; prm_cmd = 8'h80;
    prev = led; last = 0; nchg = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (led !== prev) begin
        n_cmp++;
        if (!((led === 8'h01 && ind_prm_prd === 1'b1) || (led === 8'h80 && ind_prm_prd === 1'b0))) begin
          n_err++; $display("FAIL alt_value: got led %h ind %b want 01/1 or 80/0", led, ind_prm_prd);
        end
        if (nchg >= 2) begin
          n_cmp++;
          if (cyc - last != DWELL * 8) begin
            n_err++; $display("FAIL alt_period: got %0d clk want %0d", cyc - last, DWELL * 8);
          end
        end
        last = cyc; nchg++; prev = led;
      end
    end
    n_cmp++; if (nchg < 6) begin n_err++; $display("FAIL alt_count: got %0d changes want >= 6", nchg); end
  endtask

  task automatic test_early_exit();
    settle();
    wait_tick(); prd_cmd = 8'h01;
    wait_tick();
    @(negedge clk); prd_cmd = 8'h00;
    repeat (7) wait_tick();
    @(negedge clk); prm_cmd = 8'h10;
    wait_tick();
    n_cmp++; if (led !== 8'h01) begin n_err++; $display("FAIL early_pre: got %h want 01", led); end
    repeat (3) @(negedge clk);
    n_cmp++; if (led !== 8'h10) begin n_err++; $display("FAIL early_led: got %h want 10", led); end
    n_cmp++; if (ind_prm_prd !== 1'b0) begin n_err++; $display("FAIL early_ind: got %b want 0", ind_prm_prd); end
  endtask

  task automatic test_simultaneous();
    settle();
    @(negedge clk); prd_cmd = 8'h02; prm_cmd = 8'h04;
    repeat (2) @(negedge clk);
    n_cmp++; if (led !== 8'h02) begin n_err++; $display("FAIL simul_led: got %h want 02", led); end
    n_cmp++; if (ind_prm_prd !== 1'b1) begin n_err++; $display("FAIL simul_ind: got %b want 1", ind_prm_prd); end
    repeat (DWELL) wait_tick();
    repeat (2) @(negedge clk);
    n_cmp++; if (led !== 8'h04) begin n_err++; $display("FAIL simul_handover: got %h want 04", led); end
  endtask

  task automatic test_blink();
    int nchg, nbad;
    logic [W-1:0] prev;
    settle();
    @(negedge clk); prd_cmd = 8'h01; prm_cmd = 8'h01;
    repeat (4) @(negedge clk);
    prev = led; nchg = 0; nbad = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (led !== prev) nchg++;
`ifdef IND_BLINK_EN
      if ((led & 8'hFE) !== 8'h00) nbad++;
`else
      if (led !== 8'h01) nbad++;
`endif
      prev = led;
    end
    n_cmp++; if (nbad != 0) begin n_err++; $display("FAIL blink_value: got %0d bad cycles want 0", nbad); end
`ifdef IND_BLINK_EN
    n_cmp++; if (nchg < 10) begin n_err++; $display("FAIL blink_toggle: got %0d changes want >= 10", nchg); end
`endif
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      n_cmp++; if (led !== m_led) begin n_err++; $display("FAIL rand_led cyc %0d: got %h want %h", cyc, led, m_led); end
      n_cmp++; if (ind_prm_prd !== m_ind) begin n_err++; $display("FAIL rand_ind cyc %0d: got %b want %b", cyc, ind_prm_prd, m_ind); end
      if ($urandom_range(0, 15) == 0) prd_cmd = 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 15) == 0) prm_cmd = 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 39) == 0) begin prd_cmd = '0; prm_cmd = '0; end
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk); prd_cmd = 8'hFF; prm_cmd = 8'h00;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (led !== 8'h00) begin n_err++; $display("FAIL midrst_led: got %h want 00", led); end
    n_cmp++; if (ind_prm_prd !== 1'b0) begin n_err++; $display("FAIL midrst_ind: got %b want 0", ind_prm_prd); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (led !== 8'hFF) begin n_err++; $display("FAIL midrst_release: got %h want ff", led); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; prd_cmd = '0; prm_cmd = '0;
    test_reset();
    test_stretch();
    test_alternate();
    test_early_exit();
    test_simultaneous();
    test_blink();
    test_random();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
